// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like arbiter: owner tags, lock-state encoding and
// the bundle of request fields that is muxed onto the memory port.
package sram_like_arbiter_pkg;

  typedef enum logic {
    TAG_INST = 1'b0,
    TAG_DATA = 1'b1
  } owner_tag_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

  function automatic owner_tag_t other_tag(input owner_tag_t t);
    return (t == TAG_DATA) ? TAG_INST : TAG_DATA;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// arb_owner_fifo: 1-bit tag FIFO remembering which requester owns each
// outstanding memory request; head is visible combinationally for steering.
module arb_owner_fifo #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic [CNT_W-1:0]           count_reg;
  logic [MAX_OUTSTANDING-1:0] slot_bits;
  logic                       do_push;
  logic                       do_pop;

  assign full    = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slot_bits[rd_ptr_reg];

  // One tiny register per slot; only the slot under the write pointer loads.
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
    logic slot_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_reg <= 1'b0;
      end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        slot_reg <= push_tag;
      end
    end
    assign slot_bits[gi] = slot_reg;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the IF inst port and MEM data port.
// Define ARB_RR_EN for round-robin priority; default is fixed data > inst.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_orphan
);

  lock_state_t state_reg, state_next;
  owner_tag_t  owner_reg, owner_next;
  owner_tag_t  unlocked_pick;
  owner_tag_t  grant_tag;
  logic        grant_valid;
  logic        push;
  logic        resp_valid;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;
  logic        resp_orphan_reg;
  sram_req_t   inst_fields;
  sram_req_t   data_fields;
  sram_req_t   mem_fields;

  assign inst_fields = {inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata};
  assign data_fields = {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata};

`ifdef ARB_RR_EN
  owner_tag_t last_winner_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_reg <= TAG_INST;
    end else if (push) begin
      last_winner_reg <= grant_tag;
    end
  end

  always_comb begin
    if (inst_sram_req && data_sram_req) begin
      unlocked_pick = other_tag(last_winner_reg);
    end else begin
      unlocked_pick = data_sram_req ? TAG_DATA : TAG_INST;
    end
  end
`else
  assign unlocked_pick = data_sram_req ? TAG_DATA : TAG_INST;
`endif

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_UNLOCKED;
      owner_reg <= TAG_INST;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  // Lock FSM: next state; a presented but unaccepted request freezes its owner
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    if (state_reg == ST_UNLOCKED) begin
      if (grant_valid && !mem_addr_ok) begin
        state_next = ST_LOCKED;
        owner_next = grant_tag;
      end
    end else if (mem_addr_ok) begin
      state_next = ST_UNLOCKED;
    end
  end

  // Lock FSM: outputs (grant)
  always_comb begin
    grant_valid = 1'b0;
    grant_tag   = TAG_INST;
    if (!reset) begin
      if (state_reg == ST_LOCKED) begin
        grant_valid = 1'b1;
        grant_tag   = owner_reg;
      end else if (!fifo_full && (inst_sram_req || data_sram_req)) begin
        grant_valid = 1'b1;
        grant_tag   = unlocked_pick;
      end
    end
  end

  assign mem_fields = (grant_tag == TAG_DATA) ? data_fields : inst_fields;
  assign mem_req    = grant_valid;
  assign mem_wr     = mem_fields.wr;
  assign mem_size   = mem_fields.size;
  assign mem_addr   = mem_fields.addr;
  assign mem_wstrb  = mem_fields.wstrb;
  assign mem_wdata  = mem_fields.wdata;

  assign push              = grant_valid & mem_addr_ok;
  assign inst_sram_addr_ok = push & (grant_tag == TAG_INST);
  assign data_sram_addr_ok = push & (grant_tag == TAG_DATA);

  // Pop sees the pre-push FIFO, so a same-cycle accept cannot claim a response
  assign resp_valid        = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_sram_data_ok = resp_valid & (fifo_head == TAG_INST);
  assign data_sram_data_ok = resp_valid & (fifo_head == TAG_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_orphan_reg <= 1'b0;
    end else begin
      resp_orphan_reg <= mem_data_ok & fifo_empty;
    end
  end
  assign resp_orphan = resp_orphan_reg;

  arb_owner_fifo #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (grant_tag),
    .pop      (resp_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios followed by random traffic,
// every cycle checked against a queue-based reference of the arbitration rules.
module tb_sram_like_arbiter;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, resp_orphan;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: owners of outstanding requests in issue order
  bit q[$];
  bit m_locked, m_owner, m_last, m_orphan;
  // expectations and observations of the last simulated cycle
  bit e_iaok, e_daok;
  logic o_iaok, o_daok, o_idok, o_ddok, o_mem_req, o_orphan;
  logic [31:0] o_mem_addr, o_irdata;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_req), .inst_sram_wr(inst_wr), .inst_sram_size(inst_size),
    .inst_sram_addr(inst_addr), .inst_sram_wstrb(inst_wstrb), .inst_sram_wdata(inst_wdata),
    .inst_sram_addr_ok(inst_addr_ok), .inst_sram_data_ok(inst_data_ok), .inst_sram_rdata(inst_rdata),
    .data_sram_req(data_req), .data_sram_wr(data_wr), .data_sram_size(data_size),
    .data_sram_addr(data_addr), .data_sram_wstrb(data_wstrb), .data_sram_wdata(data_wdata),
    .data_sram_addr_ok(data_addr_ok), .data_sram_data_ok(data_data_ok), .data_sram_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .resp_orphan(resp_orphan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the rules, compare at negedge, advance the model.
  task automatic cycle();
    bit gv, gt, full, has_resp, head;
    full = (q.size() == MAXO);
    gv = 0;
    gt = 0;
    if (!reset) begin
      if (m_locked) begin
        gv = 1; gt = m_owner;
      end else if (!full && (inst_req || data_req)) begin
        gv = 1;
`ifdef ARB_RR_EN
        gt = (inst_req && data_req) ? !m_last : data_req;
`else
        gt = data_req;
`endif
      end
    end
    e_iaok   = gv && mem_addr_ok && !gt;
    e_daok   = gv && mem_addr_ok && gt;
    has_resp = !reset && mem_data_ok && (q.size() > 0);
    head     = (q.size() > 0) ? q[0] : 1'b0;
    @(negedge clk);
    o_iaok = inst_addr_ok; o_daok = data_addr_ok; o_idok = inst_data_ok; o_ddok = data_data_ok;
    o_mem_req = mem_req; o_orphan = resp_orphan; o_mem_addr = mem_addr; o_irdata = inst_rdata;
    chk("mem_req", mem_req, gv);
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_data_ok", inst_data_ok, has_resp && !head);
    chk("data_data_ok", data_data_ok, has_resp && head);
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    chk("resp_orphan", resp_orphan, m_orphan);
    if (gv) begin
      chk("mem_addr", mem_addr, gt ? data_addr : inst_addr);
      chk("mem_wr", mem_wr, gt ? data_wr : inst_wr);
      chk("mem_size", mem_size, gt ? data_size : inst_size);
      chk("mem_wstrb", mem_wstrb, gt ? data_wstrb : inst_wstrb);
      chk("mem_wdata", mem_wdata, gt ? data_wdata : inst_wdata);
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_locked = 0; m_owner = 0; m_last = 0; m_orphan = 0;
    end else begin
      m_orphan = mem_data_ok && (q.size() == 0);
      if (has_resp) void'(q.pop_front());
      if (gv && mem_addr_ok) begin
        q.push_back(gt);
        m_last = gt;
        m_locked = 0;
      end else if (gv) begin
        m_locked = 1; m_owner = gt;
      end
    end
    $display("cyc t=%0t rst=%b ireq=%b dreq=%b aok=%b dok=%b mem_req=%b outst=%0d", $time, reset,
             inst_req, data_req, mem_addr_ok, mem_data_ok, o_mem_req, q.size());
    #1;
  endtask

  task automatic new_inst(input logic [31:0] a);
    inst_req = 1; inst_addr = a; inst_wr = 0; inst_size = 2'd2;
    inst_wstrb = 4'hf; inst_wdata = $urandom;
  endtask

  task automatic new_data(input logic [31:0] a);
    data_req = 1; data_addr = a; data_wr = $urandom_range(0, 1); data_size = 2'($urandom_range(0, 2));
    data_wstrb = 4'($urandom); data_wdata = $urandom;
  endtask

  initial begin
    bit exp_data;
    reset = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    new_inst(32'h0); inst_req = 0;
    new_data(32'h0); data_req = 0;
    #1;
    cycle(); cycle();
    reset = 0;
    cycle();
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_orphan", o_orphan, 0);

    // 1: single inst fetch and its response
    new_inst(32'h1c000000); mem_addr_ok = 1;
    cycle();
    chk("t1_iaok", o_iaok, 1);
    inst_req = 0; mem_addr_ok = 0;
    cycle();
    mem_data_ok = 1; mem_rdata = 32'h02800000;
    cycle();
    chk("t1_idok", o_idok, 1);
    chk("t1_irdata", o_irdata, 32'h02800000);
    chk("t1_ddok", o_ddok, 0);
    mem_data_ok = 0;

    // 2: both request, data first
    new_inst(32'h1c000004); new_data(32'h00001000); mem_addr_ok = 1;
    cycle();
    chk("t2_daok", o_daok, 1);
    chk("t2_iaok0", o_iaok, 0);
    data_req = 0;
    cycle();
    chk("t2_iaok1", o_iaok, 1);
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'hAAAA0000;
    cycle();
    chk("t2_ddok", o_ddok, 1);
    mem_rdata = 32'hBBBB0000;
    cycle();
    chk("t2_idok", o_idok, 1);
    mem_data_ok = 0;

    // 3: lock holds the inst request while data arrives
    new_inst(32'h1c000008);
    cycle();
    chk("t3_addr_c1", o_mem_addr, 32'h1c000008);
    new_data(32'h00002000);
    cycle();
    chk("t3_addr_c2", o_mem_addr, 32'h1c000008);
    cycle();
    chk("t3_addr_c3", o_mem_addr, 32'h1c000008);
    chk("t3_daok_c3", o_daok, 0);
    mem_addr_ok = 1;
    cycle();
    chk("t3_iaok", o_iaok, 1);
    chk("t3_daok_c4", o_daok, 0);
    inst_req = 0;
    cycle();
    chk("t3_daok_c5", o_daok, 1);
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    cycle(); cycle();
    mem_data_ok = 0;

    // 4: fill the owner FIFO
    mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      new_inst(32'h1c001000 + 32'(k * 4));
      cycle();
      chk("t4_iaok", o_iaok, 1);
    end
    new_inst(32'h1c001010);
    cycle();
    chk("t4_full_req", o_mem_req, 0);
    mem_data_ok = 1;
    cycle();
    chk("t4_full_pop_req", o_mem_req, 0);
    chk("t4_pop_idok", o_idok, 1);
    mem_data_ok = 0;
    cycle();
    chk("t4_after_pop_req", o_mem_req, 1);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int k = 0; k < 4; k++) cycle();

    // 5: response with nothing outstanding
    cycle();
    chk("t5_idok", o_idok, 0);
    chk("t5_ddok", o_ddok, 0);
    mem_data_ok = 0;
    cycle();
    chk("t5_orphan", o_orphan, 1);
    cycle();
    chk("t5_orphan_clr", o_orphan, 0);

    // 6: both hold requests for 4 grants, then reset mid-burst
    mem_addr_ok = 1;
    new_inst(32'h1c002000); new_data(32'h00003000);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_data = (k % 2 == 0);
`else
      exp_data = 1;
`endif
      cycle();
      chk("t6_daok", o_daok, exp_data);
      chk("t6_iaok", o_iaok, !exp_data);
      if (o_daok === 1'b1) new_data(data_addr + 4);
      if (o_iaok === 1'b1) new_inst(inst_addr + 4);
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    reset = 1; mem_data_ok = 1;
    cycle();
    reset = 0;
    cycle();
    chk("t6_rst_idok", o_idok, 0);
    chk("t6_rst_ddok", o_ddok, 0);
    mem_data_ok = 0;
    cycle();
    chk("t6_rst_orphan", o_orphan, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (!inst_req && $urandom_range(0, 2) == 0) new_inst($urandom);
      if (!data_req && $urandom_range(0, 2) == 0) new_data($urandom);
      mem_addr_ok = ($urandom_range(0, 1) == 0);
      mem_data_ok = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
      mem_rdata   = $urandom;
      reset       = ($urandom_range(0, 199) == 0);
      cycle();
      if (e_iaok) inst_req = 0;
      if (e_daok) data_req = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
